// File: rtl/f36m_cubic_iter_pkg.sv
// Shared GF(3^6M) definitions for the iterated-cubing block: field sizes, digit encoding
// and the GF(3^M)/GF(3^2M) cubing helpers used by the f36m_cubic datapath.
package f36m_cubic_iter_pkg;

  localparam int M        = 97;
  localparam int WIDTH    = 2 * M;          // bits of one GF(3^M) element
  localparam int W2       = 2 * WIDTH - 1;  // msb index of a GF(3^2M) element {hi,lo}
  localparam int W6       = 6 * WIDTH - 1;  // msb index of a GF(3^6M) element {a2,a1,a0}
  localparam int POLY_MID = 12;             // GF(3^M) = F3[x]/(x^97 + x^12 + 2)

  // GF(3) digit encoding: 00=0, 01=1, 10=2 (11 never produced)
  localparam logic [1:0] D0 = 2'b00;

  typedef logic [WIDTH-1:0] f3m_t;
  typedef logic [W2:0]      f32m_t;

  function automatic logic [1:0] add3(input logic [1:0] p, input logic [1:0] q);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, q};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // negation swaps 1 and 2 and leaves 0 alone
  function automatic logic [1:0] neg3(input logic [1:0] p);
    return {p[0], p[1]};
  endfunction

  function automatic f3m_t f3m_neg(input f3m_t p);
    f3m_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = neg3(p[2*i +: 2]);
    return r;
  endfunction

  // u(x)^3 = u(x^3); fold degrees >= M back down using x^M = -x^12 + 1
  function automatic f3m_t f3m_cube(input f3m_t u);
    logic [1:0] t [0:3*M-3];
    f3m_t       r;
    for (int d = 0; d <= 3*M-3; d++) t[d] = D0;
    for (int i = 0; i < M; i++) t[3*i] = u[2*i +: 2];
    for (int d = 3*M-3; d >= M; d--) begin
      t[d-M+POLY_MID] = add3(t[d-M+POLY_MID], neg3(t[d]));
      t[d-M]          = add3(t[d-M], t[d]);
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = t[i];
    return r;
  endfunction

  function automatic f32m_t f32m_add(input f32m_t p, input f32m_t q);
    f32m_t r;
    for (int i = 0; i < 2*M; i++) r[2*i +: 2] = add3(p[2*i +: 2], q[2*i +: 2]);
    return r;
  endfunction

  function automatic f32m_t f32m_neg(input f32m_t p);
    f32m_t r;
    for (int i = 0; i < 2*M; i++) r[2*i +: 2] = neg3(p[2*i +: 2]);
    return r;
  endfunction

  // (lo + hi*s)^3 = lo^3 - hi^3*s because s^2 = -1
  function automatic f32m_t f32m_cube(input f32m_t p);
    return {f3m_neg(f3m_cube(p[W2 -: WIDTH])), f3m_cube(p[WIDTH-1:0])};
  endfunction

endpackage

// File: rtl/f36m_cubic.sv
// Two-stage GF(3^6M) cubing datapath: stage one cubes each GF(3^2M) part,
// stage two folds the cubed parts back onto the basis {1, r, r^2}.
module f36m_cubic
  import f36m_cubic_iter_pkg::*;
(
  input  logic        clk,
  input  logic [W6:0] x,
  output logic [W6:0] y
);

  localparam int PW = W2 + 1;

  f32m_t p0, p1, p2;

  // no reset here: the sequencer never samples y until two cycles after x settles
  always_ff @(posedge clk) begin
    p0 <= f32m_cube(x[0*PW +: PW]);
    p1 <= f32m_cube(x[1*PW +: PW]);
    p2 <= f32m_cube(x[2*PW +: PW]);
  end

  // r^3 = r + 1 gives r^6 = r^2 + 2r + 1
  always_ff @(posedge clk) begin
    y <= {p2, f32m_add(p1, f32m_neg(p2)), f32m_add(f32m_add(p0, p1), p2)};
  end

endmodule

// File: rtl/f36m_cubic_iter.sv
// Iterated cubing sequencer: c = a^(3^k) by cycling one element k times through
// the shared f36m_cubic datapath, with a start/busy/done handshake.
module f36m_cubic_iter
  import f36m_cubic_iter_pkg::*;
#(
  parameter int KW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W6:0]   a,
  input  logic [KW-1:0] k,
  output logic [W6:0]   c,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    LAT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [W6:0]   x, x_nx;
  logic [W6:0]   y;
  logic [KW-1:0] cnt, cnt_nx;

  f36m_cubic u_cubic (
    .clk (clk),
    .x   (x),
    .y   (y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      cnt   <= cnt_nx;
    end
  end

  // C1/C2 give the datapath its two cycles; LAT takes its result
  always_comb begin
    state_nx = state;
    x_nx     = x;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          x_nx     = a;
          cnt_nx   = k;
          state_nx = (k == '0) ? FIN : C1;
        end
      end
      C1:  state_nx = C2;
      C2:  state_nx = LAT;
      LAT: begin
        x_nx     = y;
        cnt_nx   = cnt - KW'(1);
        state_nx = (cnt == KW'(1)) ? FIN : C1;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign c    = x;
  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_f36m_cubic_iter.sv
// Directed self-checking bench for f36m_cubic_iter with an independent
// multiply-based GF(3^6M) cubing model.
module tb_f36m_cubic_iter;
  import f36m_cubic_iter_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [W6:0] a;
  logic [9:0]  k;
  logic [W6:0] c;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  f36m_cubic_iter #(.KW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .k     (k),
    .c     (c),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // model: GF(3^M) product by schoolbook multiplication, reduced with x^97 = 2x^12 + 1
  function automatic f3m_t m_mul(input f3m_t p, input f3m_t q);
    int   pd [M];
    int   qd [M];
    int   acc [2*M-1];
    int   t;
    f3m_t r;
    for (int i = 0; i < M; i++) begin
      pd[i] = int'(p[2*i +: 2]);
      qd[i] = int'(q[2*i +: 2]);
    end
    for (int i = 0; i < 2*M-1; i++) acc[i] = 0;
    for (int i = 0; i < M; i++)
      if (pd[i] != 0)
        for (int j = 0; j < M; j++) acc[i+j] += pd[i] * qd[j];
    for (int d = 2*M-2; d >= M; d--) begin
      t = acc[d] % 3;
      acc[d-M+12] += 2 * t;
      acc[d-M]    += t;
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(acc[i] % 3);
    return r;
  endfunction

  function automatic f3m_t m_cube3m(input f3m_t u);
    return m_mul(m_mul(u, u), u);
  endfunction

  function automatic f3m_t m_neg3m(input f3m_t p);
    f3m_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((3 - int'(p[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic f32m_t m_add2(input f32m_t p, input f32m_t q, input int sign);
    f32m_t r;
    for (int i = 0; i < 2*M; i++)
      r[2*i +: 2] = 2'((int'(p[2*i +: 2]) + 3 + sign * int'(q[2*i +: 2])) % 3);
    return r;
  endfunction

  // a^3 = a0^3 + a1^3 r^3 + a2^3 r^6 with r^3 = r + 1 and s^2 = -1
  function automatic logic [W6:0] m_cube6(input logic [W6:0] v);
    f32m_t q [3];
    f32m_t part;
    for (int n = 0; n < 3; n++) begin
      part = v[n*(W2+1) +: W2+1];
      q[n] = {m_neg3m(m_cube3m(part[W2 -: WIDTH])), m_cube3m(part[WIDTH-1:0])};
    end
    return {q[2], m_add2(q[1], q[2], -1), m_add2(m_add2(q[0], q[1], 1), q[2], 1)};
  endfunction

  function automatic logic [W6:0] m_iter(input logic [W6:0] v, input int n);
    logic [W6:0] e;
    e = v;
    for (int i = 0; i < n; i++) e = m_cube6(e);
    return e;
  endfunction

  function automatic logic [W6:0] rand_elem();
    logic [W6:0] r;
    for (int i = 0; i < 3*WIDTH; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic int first_diff(input logic [W6:0] p, input logic [W6:0] q);
    for (int i = 0; i <= W6; i++) if (p[i] !== q[i]) return i;
    return 0;
  endfunction

  task automatic checkSignal(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkLatency(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s latency: observed=%0d expected=%0d cycles", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [W6:0] exp);
    int bit_at;
    int base;
    checks++;
    assert (c === exp) else begin
      errors++;
      bit_at = first_diff(c, exp);
      base   = (bit_at / 64) * 64;
      if (base > W6 + 1 - 64) base = W6 + 1 - 64;
      $error("[TB] FAIL %s c: first bad bit %0d, observed[%0d+:64]=%h expected=%h",
             tag, bit_at, base, c[base +: 64], exp[base +: 64]);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W6:0] exp_c,
                             input int exp_cyc, input int cyc);
    checkLatency(tag, cyc, exp_cyc);
    checkResult(tag, exp_c);
  endtask

  // returns on the negedge of cycle 1 after the accepting edge
  task automatic applyStimulus(input logic [W6:0] av, input logic [9:0] kv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    k     = kv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int first, input int limit, output int cyc);
    cyc = first;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [W6:0] va, vb, two, e;
  logic [9:0]  kv;
  int          cyc;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    k     = '0;
    #1;
    checkSignal("reset_busy", busy, 1'b0);
    checkSignal("reset_done", done, 1'b0);
    checkResult("reset_c", '0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] k=0 passthrough");
    va = rand_elem();
    applyStimulus(va, 10'd0);
    waitDone(1, 11, cyc);
    checkOutput("k0", va, 1, cyc);
    checkSignal("k0_busy_fin", busy, 1'b1);
    @(negedge clk);
    checkSignal("k0_busy_after", busy, 1'b0);
    checkSignal("k0_done_after", done, 1'b0);

    $display("[TB] k=1 on constant 2");
    two      = '0;
    two[1:0] = 2'b10;
    applyStimulus(two, 10'd1);
    waitDone(1, 14, cyc);
    checkOutput("k1_two", two, 4, cyc);

    $display("[TB] k=1 on random element");
    va = rand_elem();
    applyStimulus(va, 10'd1);
    waitDone(1, 14, cyc);
    checkOutput("k1_rand", m_cube6(va), 4, cyc);

    $display("[TB] k=6M Frobenius order");
    va = rand_elem();
    applyStimulus(va, 10'd582);
    waitDone(1, 1757, cyc);
    checkOutput("k582", va, 1747, cyc);

    $display("[TB] k=5 on random element");
    va = rand_elem();
    applyStimulus(va, 10'd5);
    waitDone(1, 26, cyc);
    checkOutput("k5", m_iter(va, 5), 16, cyc);

    $display("[TB] start pulses while busy");
    va = rand_elem();
    vb = rand_elem();
    applyStimulus(va, 10'd3);
    start = 1'b1;
    a     = vb;
    k     = 10'd7;
    @(negedge clk);
    a     = rand_elem();
    @(negedge clk);
    k     = 10'd1;
    @(negedge clk);
    start = 1'b0;
    waitDone(4, 20, cyc);
    checkOutput("ignore", m_iter(va, 3), 10, cyc);
    start = 1'b1;
    a     = vb;
    k     = 10'd0;
    @(negedge clk);
    start = 1'b0;
    checkSignal("ignore_fin_busy", busy, 1'b0);
    @(negedge clk);
    checkSignal("ignore_fin_busy2", busy, 1'b0);
    checkResult("ignore_hold", m_iter(va, 3));

    $display("[TB] reset in the middle of k=10");
    va = rand_elem();
    applyStimulus(va, 10'd10);
    repeat (8) @(negedge clk);
    checkResult("mid_before_reset", m_iter(va, 2));
    checkSignal("mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    checkResult("mid_reset_c", '0);
    checkSignal("mid_reset_busy", busy, 1'b0);
    checkSignal("mid_reset_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    vb = rand_elem();
    applyStimulus(vb, 10'd2);
    waitDone(1, 17, cyc);
    checkOutput("after_reset_k2", m_iter(vb, 2), 7, cyc);

    $display("[TB] random regression");
    for (int n = 0; n < 200; n++) begin
      va = rand_elem();
      kv = 10'($urandom_range(0, 20));
      e  = m_iter(va, int'(kv));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(va, kv);
      waitDone(1, 3 * int'(kv) + 11, cyc);
      checkOutput($sformatf("regr%0d_k%0d", n, kv), e, 3 * int'(kv) + 1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
